// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: sequences one WIDTH-bit add/subtract through a shared CHUNK-bit adder slice, LSB chunk first
module adder_seq_ctrl #(
    parameter  int WIDTH  = 12,
    parameter  int CHUNK  = 3,
    localparam int NCHUNK = WIDTH / CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [CHUNK-1:0] add_a,
    output logic [CHUNK-1:0] add_b,
    output logic             add_cin,
    input  logic [CHUNK-1:0] add_s,
    input  logic             add_cout
);
    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             run;
    logic             last;

    // Operands shift right one chunk per pass so the active chunk is always the low slice;
    // the result shifts in from the top and is fully aligned after NCHUNK passes.
    assign run       = state_q == RUN;
    assign last      = idx_q == IW'(NCHUNK - 1);
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign sum       = res_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign add_a     = run ? a_q[CHUNK-1:0] : '0;
    assign add_b     = run ? b_q[CHUNK-1:0] : '0;
    assign add_cin   = run & carry_q;

    // Next-state and datapath update; at the last pass the low slice holds the operand MSBs
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = a;
                b_d     = sub ? ~b : b;
                carry_d = sub | cin;
                idx_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                res_d   = {add_s, res_q[WIDTH-1:CHUNK]};
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                carry_d = add_cout;
                idx_d   = idx_q + 1'b1;
                if (last) begin
                    state_d = DONE;
                    cout_d  = add_cout;
                    ovf_d   = (a_q[CHUNK-1] == b_q[CHUNK-1]) && (add_s[CHUNK-1] != a_q[CHUNK-1]);
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule
